alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 req0_func / req1_func  input  3  op code: 000 add, 001 sub, 010 and, 011 or, others reserved.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  DATA_W  operand_1 and operand_2 of requester N.
REQ-008 rsp0_valid / rsp1_valid  output  1  result available for requester N.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester N consumes result.
REQ-010 rsp_result  output  DATA_W  result of the current transaction, shared by both responders.
REQ-011 alu_func  output  3  op code driven to the shared ALU.
REQ-012 alu_op1, alu_op2  output  DATA_W  operands driven to the shared ALU.
REQ-013 alu_result  input  DATA_W  combinational result from the shared ALU.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM SHALL have states IDLE, EXEC, RESP; one transaction outstanding at most.
REQ-016 reqN_ready SHALL be high only in IDLE and only for the granted requester (combinational from valids and last_grant).
REQ-017 Grant: only one valid -> that one; both valid -> the requester not equal to last_grant (round-robin); none -> no grant.
REQ-018 Handshake reqN_valid & reqN_ready SHALL capture func, a, b, owner=N, set last_grant=N, move IDLE->EXEC.
REQ-019 alu_func/alu_op1/alu_op2 SHALL always drive the captured registers (stable through EXEC).
REQ-020 EXEC lasts exactly one cycle; at its end alu_result SHALL be captured into the result register, state -> RESP.
REQ-021 In RESP, rsp{owner}_valid SHALL be 1, the other rsp valid 0, rsp_result = captured result, held stable until rspN_ready.
REQ-022 rsp{owner}_valid & rsp{owner}_ready SHALL move RESP->IDLE; rsp_ready of the non-owner SHALL be ignored.
REQ-023 Latency: accept in cycle T -> rsp valid from cycle T+2; minimum 3 cycles accept-to-accept.
REQ-024 Reserved op codes SHALL pass through unfiltered; the returned result is whatever the ALU yields (0 for the team ALU).
REQ-025 Result width SHALL equal DATA_W; overflow/borrow wrap modulo 2^DATA_W, no flags.
REQ-026 Requests arriving outside IDLE SHALL see ready=0 and remain pending; requesters hold valid and payload until ready.
REQ-027 New requests SHALL NOT be accepted in the cycle the response handshake completes (IDLE entered the next cycle).

Reset
REQ-028 rst_n low SHALL immediately force IDLE, busy=0, both rsp valid=0, result/captured func/operands=0, owner=0, last_grant=1 (requester 0 wins the first tie).
REQ-029 Reset during EXEC or RESP SHALL discard the transaction with no response issued.
REQ-030 After rst_n deasserts, the first request SHALL be acceptable on the first rising edge.

Verification
REQ-031 req0 valid, func=000, a=5, b=7 -> req0_ready same cycle, rsp0_valid=1 two cycles later, rsp_result=12.
REQ-032 Both valid after reset (req0 sub 10-3, req1 and F0&3C) -> req0 served first (result 7), then req1 (result 0x30); third tie grants req0 again.
REQ-033 req1 func=001, a=0, b=1 -> rsp_result=0xFFFFFFFF (wrap).
REQ-034 req0 func=111 -> rsp0_valid with rsp_result=0; FSM returns to IDLE normally.
REQ-035 Hold rsp0_ready=0 for 5 cycles with req1 valid -> rsp0_valid and rsp_result stable, req1_ready=0 throughout; req1 accepted the cycle after rsp0 handshake.
REQ-036 Assert rst_n=0 during RESP -> rsp valids drop immediately, busy=0, no response delivered after reset release.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared ALU.
// One transaction is in flight at a time: IDLE accepts, EXEC samples the
// ALU, RESP holds the result for the owning requester until it is consumed.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_func,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_func,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  // responses
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  // shared ALU
  output logic [2:0]        alu_func,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]        func;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  state_t            state;
  req_t              cap;        // operation captured at accept
  req_t [1:0]        req_in;
  logic [1:0]        vld;
  logic [1:0]        gnt;
  logic [1:0]        rdy;
  logic              owner;
  logic              last_grant;
  logic [DATA_W-1:0] result_q;
  logic              rsp0_q;
  logic              rsp1_q;
  logic              busy_q;
  logic              rsp_done;

  assign req_in[0] = {req0_func, req0_a, req0_b};
  assign req_in[1] = {req1_func, req1_a, req1_b};
  assign vld       = {req1_valid, req0_valid};

  // Round-robin grant: a lone valid wins; on a tie the requester that was
  // not granted last time wins. last_grant resets to 1 so req0 wins first.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = vld[0] & (~vld[1] | last_grant);
    gnt[1] = vld[1] & (~vld[0] | ~last_grant);
  end

  // Ready only while idle; never in the response handshake cycle since the
  // FSM is still in RESP then.
  assign rdy        = gnt & {2{state == IDLE}};
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  // Non-owner rsp_ready is masked by the owner-specific valid.
  assign rsp_done = (rsp0_q & rsp0_ready) | (rsp1_q & rsp1_ready);

  // Transaction FSM with registered response valids and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      result_q   <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|rdy) begin
            cap        <= rdy[1] ? req_in[1] : req_in[0];
            owner      <= rdy[1];
            last_grant <= rdy[1];
            busy_q     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // Operands have been stable on the ALU for the whole cycle.
          result_q <= alu_result;
          rsp0_q   <= ~owner;
          rsp1_q   <= owner;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          rsp0_q <= 1'b0;
          rsp1_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign alu_func   = cap.func;
  assign alu_op1    = cap.a;
  assign alu_op2    = cap.b;
  assign rsp_result = result_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign busy       = busy_q;

endmodule
